// File: rtl/microgreen_pkg.sv
// Shared constants and types for the microgreen feature front end.
package microgreen_pkg;

    // Default log2 of frames averaged per window.
    localparam int WINDOW_LOG2_DEF = 3;

    // Channel tags carried on sample_chan.
    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;
    localparam logic [1:0] CH_H = 2'd3;

    localparam int NUM_CH = 4;

    // Window control states.
    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_AVG   = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

endpackage

// File: rtl/microgreen_chan_acc.sv
// One channel: running sum over the window, live clip bit, and the
// registered round-half-up average captured when the window closes.
module microgreen_chan_acc
    import microgreen_pkg::*;
#(
    parameter int WINDOW_LOG2 = WINDOW_LOG2_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,   // drop the partial window
    input  logic       load_i,  // start a fresh window with din_i
    input  logic       add_i,   // accumulate din_i
    input  logic       cap_i,   // capture the average into the feature register
    input  logic [7:0] din_i,
    output logic [7:0] feat_o,
    output logic       clip_o
);

    // 255 * 2^W + 2^(W-1) still fits, so rounding never overflows.
    localparam int            AW   = 8 + WINDOW_LOG2;
    localparam logic [AW-1:0] HALF = AW'(1 << (WINDOW_LOG2 - 1));

    logic [AW-1:0] acc_q, acc_d;
    logic          clip_q, clip_d;
    logic [AW-1:0] rnd;
    logic [7:0]    feat_q;
    logic          fclip_q;
    logic          hit;

    assign hit = (din_i == 8'hFF);
    assign rnd = acc_q + HALF;

    // Next value of the running sum and clip bit; load beats clear beats add.
    always_comb begin
        acc_d  = acc_q;
        clip_d = clip_q;
        if (load_i) begin
            acc_d  = AW'(din_i);
            clip_d = hit;
        end else if (clr_i) begin
            acc_d  = '0;
            clip_d = 1'b0;
        end else if (add_i) begin
            acc_d  = acc_q + AW'(din_i);
            clip_d = clip_q | hit;
        end
    end

    // Accumulator and clip state.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            clip_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            clip_q <= clip_d;
        end
    end

    // Feature register: holds the last average until the next capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            feat_q  <= '0;
            fclip_q <= 1'b0;
        end else if (cap_i) begin
            feat_q  <= rnd[AW-1:WINDOW_LOG2];
            fclip_q <= clip_q;
        end
    end

    assign feat_o = feat_q;
    assign clip_o = fclip_q;

endmodule

// File: rtl/microgreen_feature_frontend.sv
// Sensor front end: collects 2^WINDOW_LOG2 frames of {R,G,B,H} samples,
// averages each channel and hands the vector to the classifier.
module microgreen_feature_frontend
    import microgreen_pkg::*;
#(
    parameter int WINDOW_LOG2 = WINDOW_LOG2_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample_in,
    input  logic [1:0] sample_chan,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic [7:0] feat_r,
    output logic [7:0] feat_g,
    output logic [7:0] feat_b,
    output logic [7:0] feat_h,
    output logic [3:0] feat_clip,
    output logic       feat_valid,
    input  logic       feat_ready,
    output logic       seq_err,
    output logic [7:0] win_cnt
);

    localparam logic [WINDOW_LOG2-1:0] LAST_FRAME = {WINDOW_LOG2{1'b1}};

    state_e                 state_q, state_d;
    logic [1:0]             exp_ch_q, exp_ch_d;
    logic [WINDOW_LOG2-1:0] frame_q, frame_d;
    logic                   seq_err_q, seq_err_d;
    logic [7:0]             win_cnt_q, win_cnt_d;

    logic                   accept;
    logic                   in_order;
    logic                   clr_all;
    logic                   restart;
    logic                   cap;
    logic [NUM_CH-1:0]      add_en;
    logic [NUM_CH-1:0]      load_en;
    logic [NUM_CH-1:0][7:0] feat_vec;
    logic [NUM_CH-1:0]      clip_vec;

    assign sample_ready = (state_q == ST_ACCUM);
    assign feat_valid   = (state_q == ST_OUT);
    assign accept       = sample_valid & sample_ready;
    assign in_order     = (sample_chan == exp_ch_q);
    // Only channel R can begin a restarted window.
    assign load_en      = {{(NUM_CH-1){1'b0}}, restart};

    // Window sequencing: next state, counters and per-channel strobes.
    always_comb begin
        state_d   = state_q;
        exp_ch_d  = exp_ch_q;
        frame_d   = frame_q;
        seq_err_d = seq_err_q;
        win_cnt_d = win_cnt_q;
        clr_all   = 1'b0;
        restart   = 1'b0;
        cap       = 1'b0;
        add_en    = '0;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (in_order) begin
                        add_en[sample_chan] = 1'b1;
                        exp_ch_d = exp_ch_q + 2'd1;
                        if (exp_ch_q == CH_H) begin
                            frame_d = frame_q + 1'b1;
                            if (frame_q == LAST_FRAME)
                                state_d = ST_AVG;
                        end
                    end else begin
                        // Out-of-order: drop the window; an R tag starts a new one.
                        seq_err_d = 1'b1;
                        clr_all   = 1'b1;
                        frame_d   = '0;
                        if (sample_chan == CH_R) begin
                            restart  = 1'b1;
                            exp_ch_d = CH_G;
                        end else begin
                            exp_ch_d = CH_R;
                        end
                    end
                end
            end
            ST_AVG: begin
                cap     = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (feat_ready) begin
                    clr_all   = 1'b1;
                    exp_ch_d  = CH_R;
                    frame_d   = '0;
                    win_cnt_d = win_cnt_q + 8'd1;
                    state_d   = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACCUM;
            exp_ch_q  <= CH_R;
            frame_q   <= '0;
            seq_err_q <= 1'b0;
            win_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            exp_ch_q  <= exp_ch_d;
            frame_q   <= frame_d;
            seq_err_q <= seq_err_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        microgreen_chan_acc #(
            .WINDOW_LOG2(WINDOW_LOG2)
        ) u_acc (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (clr_all),
            .load_i (load_en[c]),
            .add_i  (add_en[c]),
            .cap_i  (cap),
            .din_i  (sample_in),
            .feat_o (feat_vec[c]),
            .clip_o (clip_vec[c])
        );
    end

    assign feat_r    = feat_vec[0];
    assign feat_g    = feat_vec[1];
    assign feat_b    = feat_vec[2];
    assign feat_h    = feat_vec[3];
    assign feat_clip = clip_vec;
    assign seq_err   = seq_err_q;
    assign win_cnt   = win_cnt_q;

endmodule

// File: tb/tb_microgreen_feature_frontend.sv
// Directed + randomized bench for microgreen_feature_frontend (WINDOW_LOG2=3).
module tb_microgreen_feature_frontend;

    localparam int WL = 3;
    localparam int NF = 1 << WL;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sample_in;
    logic [1:0] sample_chan;
    logic       sample_valid;
    logic       sample_ready;
    logic [7:0] feat_r, feat_g, feat_b, feat_h;
    logic [3:0] feat_clip;
    logic       feat_valid;
    logic       feat_ready;
    logic       seq_err;
    logic [7:0] win_cnt;

    microgreen_feature_frontend #(.WINDOW_LOG2(WL)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_chan  (sample_chan),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .feat_r       (feat_r),
        .feat_g       (feat_g),
        .feat_b       (feat_b),
        .feat_h       (feat_h),
        .feat_clip    (feat_clip),
        .feat_valid   (feat_valid),
        .feat_ready   (feat_ready),
        .seq_err      (seq_err),
        .win_cnt      (win_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         win_v[NF][4];
    int         exp_f[4];
    logic [3:0] exp_clip;
    logic       exp_seq;
    logic [7:0] exp_wc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: per-channel mean over the window, rounded half up.
    task automatic model_window();
        for (int c = 0; c < 4; c++) begin
            int sum = 0;
            exp_clip[c] = 1'b0;
            for (int f = 0; f < NF; f++) begin
                sum += win_v[f][c];
                if (win_v[f][c] == 255) exp_clip[c] = 1'b1;
            end
            exp_f[c] = (sum + NF / 2) / NF;
        end
    endtask

    task automatic fill_const(input int r, input int g, input int b, input int h);
        for (int f = 0; f < NF; f++) begin
            win_v[f][0] = r; win_v[f][1] = g; win_v[f][2] = b; win_v[f][3] = h;
        end
    endtask

    task automatic fill_rand();
        for (int f = 0; f < NF; f++)
            for (int c = 0; c < 4; c++)
                win_v[f][c] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
    endtask

    task automatic send(input int ch, input int val, input int gap);
        repeat (gap) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
        @(negedge clk);
        sample_valid = 1'b1;
        sample_chan  = 2'(ch);
        sample_in    = 8'(val);
    endtask

    // Sends the window from linear sample index 'start' onward.
    task automatic feed(input int start, input int maxgap);
        for (int i = start; i < 4 * NF; i++)
            send(i % 4, win_v[i / 4][i % 4], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic check_feat(input string tag);
        chk({tag, " feat_r"}, 32'(feat_r), 32'(exp_f[0]));
        chk({tag, " feat_g"}, 32'(feat_g), 32'(exp_f[1]));
        chk({tag, " feat_b"}, 32'(feat_b), 32'(exp_f[2]));
        chk({tag, " feat_h"}, 32'(feat_h), 32'(exp_f[3]));
        chk({tag, " clip"},   32'(feat_clip), 32'(exp_clip));
        chk({tag, " valid"},  32'(feat_valid), 32'd1);
    endtask

    // Called right after the final sample was driven: valid must rise at T+2.
    task automatic expect_vec(input string tag);
        model_window();
        @(negedge clk);
        sample_valid = 1'b0;
        chk({tag, " T+1 valid"}, 32'(feat_valid), 32'd0);
        @(negedge clk);
        check_feat(tag);
        chk({tag, " seq_err"}, 32'(seq_err), 32'(exp_seq));
    endtask

    // Backpressure for 'hold' cycles while offering samples, then handshake.
    task automatic consume(input string tag, input int hold);
        for (int k = 0; k < hold; k++) begin
            sample_valid = 1'b1;
            sample_chan  = 2'd0;
            sample_in    = 8'hFF;
            chk({tag, " hold ready"}, 32'(sample_ready), 32'd0);
            check_feat({tag, " hold"});
            @(negedge clk);
        end
        sample_valid = 1'b0;
        feat_ready   = 1'b1;
        @(negedge clk);
        feat_ready = 1'b0;
        exp_wc++;
        chk({tag, " post valid"}, 32'(feat_valid), 32'd0);
        chk({tag, " post ready"}, 32'(sample_ready), 32'd1);
        chk({tag, " win_cnt"}, 32'(win_cnt), 32'(exp_wc));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " valid"}, 32'(feat_valid), 32'd0);
        chk({tag, " ready"}, 32'(sample_ready), 32'd1);
        chk({tag, " feats"}, {feat_r, feat_g, feat_b, feat_h}, 32'd0);
        chk({tag, " clip"}, 32'(feat_clip), 32'd0);
        chk({tag, " seq_err"}, 32'(seq_err), 32'd0);
        chk({tag, " win_cnt"}, 32'(win_cnt), 32'd0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        sample_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_wc  = 8'd0;
        exp_seq = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sample_valid = 1'b0; sample_chan = 2'd0; sample_in = 8'd0; feat_ready = 1'b0;
        exp_wc = 8'd0; exp_seq = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // Constant window, no gaps.
        fill_const(10, 20, 30, 40);
        feed(0, 0);
        expect_vec("const");
        consume("const", 0);

        // Rounding boundary on R.
        fill_const(0, 0, 0, 0);
        win_v[NF-1][0] = 4;
        feed(0, 0);
        expect_vec("round_up");
        consume("round_up", 0);
        win_v[NF-1][0] = 3;
        feed(0, 1);
        expect_vec("round_dn");
        consume("round_dn", 2);

        // Backpressure: offered samples must not leak into the next window.
        fill_rand();
        feed(0, 2);
        expect_vec("bp");
        consume("bp", 5);
        fill_rand();
        feed(0, 0);
        expect_vec("after_bp");
        consume("after_bp", 0);

        // Order error (0,2) clears the window.
        send(0, 200, 0);
        send(2, 50, 0);
        @(negedge clk);
        sample_valid = 1'b0;
        exp_seq = 1'b1;
        chk("seqerr flag", 32'(seq_err), 32'd1);
        fill_const(7, 7, 7, 7);
        feed(0, 0);
        expect_vec("seqerr");
        consume("seqerr", 0);

        // Out-of-order R restarts the window with that sample.
        for (int i = 0; i < 10; i++) send(i % 4, 250, 0);
        fill_rand();
        win_v[0][0] = int'($urandom_range(0, 254));
        send(0, win_v[0][0], 0);
        feed(1, 1);
        expect_vec("restart");
        consume("restart", 1);

        // All samples at full scale.
        fill_const(255, 255, 255, 255);
        feed(0, 0);
        expect_vec("sat");
        consume("sat", 0);

        // Reset in frame 5 discards the partial window.
        fill_rand();
        for (int i = 0; i < 5 * 4 + 2; i++) send(i % 4, win_v[i / 4][i % 4], 0);
        pulse_rst();
        check_zero("rst_mid");
        fill_rand();
        feed(0, 1);
        expect_vec("post_rst");
        consume("post_rst", 0);

        // Reset while a vector is pending.
        fill_rand();
        feed(0, 0);
        expect_vec("rst_out");
        pulse_rst();
        check_zero("rst_out");

        // Random windows with random gaps and backpressure.
        for (int w = 0; w < 6; w++) begin
            fill_rand();
            feed(0, 3);
            expect_vec("rand");
            consume("rand", int'($urandom_range(0, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
